id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS pipeline, directly downstream of the opcode controller.
- Captures the controller's EX/MEM/WB control bundles plus the decoded operands each cycle.
- Contains load-use hazard detection and bubble insertion, and discards the ID instruction on branch/jump flush.
- Converts don't-care control bits to 0 and counts load-use bubbles for performance debug.

---
 rtl/id_ex_stage_if.sv | 62 ++++++
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    // pipeline control from outside the stage
    logic              hold;
    logic              flush;

    // decode-stage bundle from the opcode controller and register file
    logic [3:0]        id_ex;
    logic [1:0]        id_mem;
    logic [1:0]        id_wb;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  id_rd;
    logic [DATA_W-1:0] id_rd1;
    logic [DATA_W-1:0] id_rd2;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_pc4;

    // stall requests back to the front end
    logic              pc_write;
    logic              if_id_write;

    // execute-stage register contents
    logic              ex_valid;
    logic [3:0]        ex_ctl_ex;
    logic [1:0]        ex_ctl_mem;
    logic [1:0]        ex_ctl_wb;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [REG_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd2;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_pc4;
    logic [CNT_W-1:0]  bubble_cnt;

    // decode side: drives the ID bundle, observes the stage outputs
    modport master (
        output hold, flush,
        output id_ex, id_mem, id_wb, id_rs, id_rt, id_rd,
        output id_rd1, id_rd2, id_imm, id_pc4,
        input  pc_write, if_id_write,
        input  ex_valid, ex_ctl_ex, ex_ctl_mem, ex_ctl_wb,
        input  ex_rs, ex_rt, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_pc4,
        input  bubble_cnt
    );

    // the pipeline register itself
    modport slave (
        input  hold, flush,
        input  id_ex, id_mem, id_wb, id_rs, id_rt, id_rd,
        input  id_rd1, id_rd2, id_imm, id_pc4,
        output pc_write, if_id_write,
        output ex_valid, ex_ctl_ex, ex_ctl_mem, ex_ctl_wb,
        output ex_rs, ex_rt, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_pc4,
        output bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion and flush
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Anything that is not a clean 1 (0, X, Z) becomes 0 so EX never sees unknown control.
    function automatic logic clean_bit(input logic b);
        case (b)
            1'b1:    clean_bit = 1'b1;
            default: clean_bit = 1'b0;
        endcase
    endfunction

    logic              valid_q;
    logic [3:0]        ctl_ex_q;
    logic [1:0]        ctl_mem_q;
    logic [1:0]        ctl_wb_q;
    logic [REG_W-1:0]  rs_q;
    logic [REG_W-1:0]  rt_q;
    logic [REG_W-1:0]  rd_q;
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd2_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] pc4_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [3:0]        ex_clean;
    logic [1:0]        mem_clean;
    logic [1:0]        wb_clean;
    logic              load_use;
    logic              stall;

    // sanitise the controller bundles bit by bit
    always_comb begin
        ex_clean  = '0;
        mem_clean = '0;
        wb_clean  = '0;
        for (int i = 0; i < 4; i++) begin
            ex_clean[i] = clean_bit(bus.id_ex[i]);
        end
        for (int i = 0; i < 2; i++) begin
            mem_clean[i] = clean_bit(bus.id_mem[i]);
            wb_clean[i]  = clean_bit(bus.id_wb[i]);
        end
    end

    // a load in EX whose destination ($0 excluded) is a source of the ID instruction
    always_comb begin
        load_use = ctl_mem_q[1] & valid_q & (rt_q != '0)
                 & ((rt_q == bus.id_rs) | (rt_q == bus.id_rt));
        stall    = load_use & ~bus.flush;
    end

    // a flush overrides the stall; reset releases the front end unconditionally
    assign bus.pc_write    = ~rst | ~stall;
    assign bus.if_id_write = ~rst | ~stall;

    // register update: reset > hold > flush > load-use bubble > normal load
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            ctl_ex_q  <= '0;
            ctl_mem_q <= '0;
            ctl_wb_q  <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            imm_q     <= '0;
            pc4_q     <= '0;
            cnt_q     <= '0;
        end else if (bus.hold) begin
            valid_q   <= valid_q;
        end else if (bus.flush) begin
            // the discarded instruction's data rides along but is marked invalid
            valid_q   <= 1'b0;
            ctl_ex_q  <= '0;
            ctl_mem_q <= '0;
            ctl_wb_q  <= '0;
            rs_q      <= bus.id_rs;
            rt_q      <= bus.id_rt;
            rd_q      <= bus.id_rd;
            rd1_q     <= bus.id_rd1;
            rd2_q     <= bus.id_rd2;
            imm_q     <= bus.id_imm;
            pc4_q     <= bus.id_pc4;
        end else if (load_use) begin
            // bubble: control cleared, data fields keep the load's values
            valid_q   <= 1'b0;
            ctl_ex_q  <= '0;
            ctl_mem_q <= '0;
            ctl_wb_q  <= '0;
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            valid_q   <= 1'b1;
            ctl_ex_q  <= ex_clean;
            ctl_mem_q <= mem_clean;
            ctl_wb_q  <= wb_clean;
            rs_q      <= bus.id_rs;
            rt_q      <= bus.id_rt;
            rd_q      <= bus.id_rd;
            rd1_q     <= bus.id_rd1;
            rd2_q     <= bus.id_rd2;
            imm_q     <= bus.id_imm;
            pc4_q     <= bus.id_pc4;
        end
    end

    assign bus.ex_valid   = valid_q;
    assign bus.ex_ctl_ex  = ctl_ex_q;
    assign bus.ex_ctl_mem = ctl_mem_q;
    assign bus.ex_ctl_wb  = ctl_wb_q;
    assign bus.ex_rs      = rs_q;
    assign bus.ex_rt      = rt_q;
    assign bus.ex_rd      = rd_q;
    assign bus.ex_rd1     = rd1_q;
    assign bus.ex_rd2     = rd2_q;
    assign bus.ex_imm     = imm_q;
    assign bus.ex_pc4     = pc4_q;
    assign bus.bubble_cnt = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed checks of the ID/EX pipeline register
module tb_id_ex_stage;
    logic        clk;
    logic        rst;
    logic        hold;
    logic        flush;
    logic [3:0]  id_ex;
    logic [1:0]  id_mem;
    logic [1:0]  id_wb;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rd1, id_rd2, id_imm, id_pc4;

    int checks;
    int errors;
    int exp_cnt;
    int exp_small;

    id_ex_stage_if #(.DATA_W(32), .REG_W(5), .CNT_W(16)) u_bus ();
    id_ex_stage_if #(.DATA_W(32), .REG_W(5), .CNT_W(2))  s_bus ();

    id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(u_bus));
    id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(2))  s_dut (.clk(clk), .rst(rst), .bus(s_bus));

    assign u_bus.hold = hold;     assign s_bus.hold = hold;
    assign u_bus.flush = flush;   assign s_bus.flush = flush;
    assign u_bus.id_ex = id_ex;   assign s_bus.id_ex = id_ex;
    assign u_bus.id_mem = id_mem; assign s_bus.id_mem = id_mem;
    assign u_bus.id_wb = id_wb;   assign s_bus.id_wb = id_wb;
    assign u_bus.id_rs = id_rs;   assign s_bus.id_rs = id_rs;
    assign u_bus.id_rt = id_rt;   assign s_bus.id_rt = id_rt;
    assign u_bus.id_rd = id_rd;   assign s_bus.id_rd = id_rd;
    assign u_bus.id_rd1 = id_rd1; assign s_bus.id_rd1 = id_rd1;
    assign u_bus.id_rd2 = id_rd2; assign s_bus.id_rd2 = id_rd2;
    assign u_bus.id_imm = id_imm; assign s_bus.id_imm = id_imm;
    assign u_bus.id_pc4 = id_pc4; assign s_bus.id_pc4 = id_pc4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [3:0] e, input logic [1:0] m, input logic [1:0] w,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] pc);
        id_ex = e; id_mem = m; id_wb = w;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rd1 = d1; id_rd2 = d2; id_imm = d1 ^ d2; id_pc4 = pc;
    endtask

    task automatic test_reset();
        rst = 1'b0; hold = 1'b0; flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_id(4'($urandom), 2'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), $urandom, $urandom, $urandom);
            step();
        end
        checks++; if ({u_bus.ex_ctl_ex, u_bus.ex_ctl_mem, u_bus.ex_ctl_wb} !== 8'h00) begin errors++; $display("FAIL reset_ctl got %h exp 00", {u_bus.ex_ctl_ex, u_bus.ex_ctl_mem, u_bus.ex_ctl_wb}); end
        checks++; if ({u_bus.ex_rs, u_bus.ex_rt, u_bus.ex_rd} !== 15'h0) begin errors++; $display("FAIL reset_regs got %h exp 0", {u_bus.ex_rs, u_bus.ex_rt, u_bus.ex_rd}); end
        checks++; if ({u_bus.ex_rd1, u_bus.ex_rd2, u_bus.ex_imm, u_bus.ex_pc4} !== 128'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {u_bus.ex_rd1, u_bus.ex_rd2, u_bus.ex_imm, u_bus.ex_pc4}); end
        checks++; if (u_bus.ex_valid !== 1'b0 || u_bus.bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_valid_cnt got %b/%0d exp 0/0", u_bus.ex_valid, u_bus.bubble_cnt); end
        checks++; if (u_bus.pc_write !== 1'b1 || u_bus.if_id_write !== 1'b1) begin errors++; $display("FAIL reset_stall got %b%b exp 11", u_bus.pc_write, u_bus.if_id_write); end
        rst = 1'b1;
        exp_cnt = 0; exp_small = 0;
        set_id(4'h0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_rtype();
        set_id(4'b0101, 2'b00, 2'b10, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h104);
        #1;
        checks++; if (u_bus.pc_write !== 1'b1) begin errors++; $display("FAIL rtype_pcw got %b exp 1", u_bus.pc_write); end
        step();
        checks++; if (u_bus.ex_ctl_ex !== 4'b0101 || u_bus.ex_ctl_wb !== 2'b10 || u_bus.ex_ctl_mem !== 2'b00) begin errors++; $display("FAIL rtype_ctl got %b %b %b exp 0101 00 10", u_bus.ex_ctl_ex, u_bus.ex_ctl_mem, u_bus.ex_ctl_wb); end
        checks++; if (u_bus.ex_rd1 !== 32'h11 || u_bus.ex_rd2 !== 32'h22 || u_bus.ex_imm !== 32'h33 || u_bus.ex_pc4 !== 32'h104) begin errors++; $display("FAIL rtype_data got %h %h %h %h exp 11 22 33 104", u_bus.ex_rd1, u_bus.ex_rd2, u_bus.ex_imm, u_bus.ex_pc4); end
        checks++; if (u_bus.ex_rs !== 5'd1 || u_bus.ex_rt !== 5'd2 || u_bus.ex_rd !== 5'd3 || u_bus.ex_valid !== 1'b1) begin errors++; $display("FAIL rtype_regs got %0d %0d %0d v%b exp 1 2 3 v1", u_bus.ex_rs, u_bus.ex_rt, u_bus.ex_rd, u_bus.ex_valid); end
    endtask

    task automatic test_load_use();
        set_id(4'b1000, 2'b10, 2'b11, 5'd9, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h200);
        step();
        set_id(4'b0101, 2'b00, 2'b10, 5'd8, 5'd10, 5'd12, 32'h33, 32'h44, 32'h204);
        #1;
        checks++; if (u_bus.pc_write !== 1'b0 || u_bus.if_id_write !== 1'b0) begin errors++; $display("FAIL lu_stall got %b%b exp 00", u_bus.pc_write, u_bus.if_id_write); end
        step();
        exp_cnt++; exp_small++;
        checks++; if ({u_bus.ex_ctl_ex, u_bus.ex_ctl_mem, u_bus.ex_ctl_wb} !== 8'h00 || u_bus.ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %h v%b exp 00 v0", {u_bus.ex_ctl_ex, u_bus.ex_ctl_mem, u_bus.ex_ctl_wb}, u_bus.ex_valid); end
        checks++; if (u_bus.ex_rt !== 5'd8 || u_bus.ex_rd1 !== 32'h1000 || u_bus.ex_pc4 !== 32'h200) begin errors++; $display("FAIL lu_bubble_data got %0d %h %h exp 8 1000 200", u_bus.ex_rt, u_bus.ex_rd1, u_bus.ex_pc4); end
        checks++; if (u_bus.bubble_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL lu_cnt got %0d exp %0d", u_bus.bubble_cnt, exp_cnt); end
        checks++; if (u_bus.pc_write !== 1'b1) begin errors++; $display("FAIL lu_release got %b exp 1", u_bus.pc_write); end
        step();
        checks++; if (u_bus.ex_ctl_ex !== 4'b0101 || u_bus.ex_rs !== 5'd8 || u_bus.ex_rd1 !== 32'h33 || u_bus.ex_valid !== 1'b1) begin errors++; $display("FAIL lu_add got %b %0d %h v%b exp 0101 8 33 v1", u_bus.ex_ctl_ex, u_bus.ex_rs, u_bus.ex_rd1, u_bus.ex_valid); end
        checks++; if (u_bus.bubble_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL lu_cnt_after got %0d exp %0d", u_bus.bubble_cnt, exp_cnt); end
    endtask

    task automatic test_no_false_hazard();
        set_id(4'b1000, 2'b10, 2'b11, 5'd4, 5'd0, 5'd0, 32'h5, 32'h0, 32'h300);
        step();
        set_id(4'b0101, 2'b00, 2'b10, 5'd0, 5'd0, 5'd6, 32'h7, 32'h8, 32'h304);
        #1;
        checks++; if (u_bus.pc_write !== 1'b1) begin errors++; $display("FAIL zero_reg_stall got %b exp 1", u_bus.pc_write); end
        step();
        checks++; if (u_bus.ex_valid !== 1'b1 || u_bus.ex_rd !== 5'd6 || u_bus.bubble_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL zero_reg_load got v%b rd%0d cnt%0d exp v1 rd6 cnt%0d", u_bus.ex_valid, u_bus.ex_rd, u_bus.bubble_cnt, exp_cnt); end
        set_id(4'b1000, 2'b01, 2'b00, 5'd4, 5'd8, 5'd0, 32'h5, 32'h9, 32'h308);
        step();
        set_id(4'b0101, 2'b00, 2'b10, 5'd8, 5'd8, 5'd7, 32'h1, 32'h2, 32'h30c);
        #1;
        checks++; if (u_bus.pc_write !== 1'b1 || u_bus.if_id_write !== 1'b1) begin errors++; $display("FAIL store_stall got %b%b exp 11", u_bus.pc_write, u_bus.if_id_write); end
        step();
        checks++; if (u_bus.ex_valid !== 1'b1 || u_bus.ex_rd !== 5'd7 || u_bus.bubble_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL store_load got v%b rd%0d cnt%0d exp v1 rd7 cnt%0d", u_bus.ex_valid, u_bus.ex_rd, u_bus.bubble_cnt, exp_cnt); end
    endtask

    task automatic test_flush_vs_lu();
        set_id(4'b1000, 2'b10, 2'b11, 5'd9, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h400);
        step();
        set_id(4'b0101, 2'b00, 2'b10, 5'd8, 5'd11, 5'd13, 32'h55, 32'h66, 32'h404);
        flush = 1'b1;
        #1;
        checks++; if (u_bus.pc_write !== 1'b1 || u_bus.if_id_write !== 1'b1) begin errors++; $display("FAIL flush_stall got %b%b exp 11", u_bus.pc_write, u_bus.if_id_write); end
        step();
        flush = 1'b0;
        checks++; if ({u_bus.ex_ctl_ex, u_bus.ex_ctl_mem, u_bus.ex_ctl_wb} !== 8'h00 || u_bus.ex_valid !== 1'b0) begin errors++; $display("FAIL flush_bubble got %h v%b exp 00 v0", {u_bus.ex_ctl_ex, u_bus.ex_ctl_mem, u_bus.ex_ctl_wb}, u_bus.ex_valid); end
        checks++; if (u_bus.bubble_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL flush_cnt got %0d exp %0d", u_bus.bubble_cnt, exp_cnt); end
        checks++; if (u_bus.ex_rs !== 5'd8 || u_bus.ex_rd1 !== 32'h55) begin errors++; $display("FAIL flush_data got %0d %h exp 8 55", u_bus.ex_rs, u_bus.ex_rd1); end
        set_id(4'b001x, 2'b00, 2'b00, 5'd2, 5'd3, 5'd0, 32'h1, 32'h1, 32'h408);
        step();
        checks++; if (u_bus.ex_ctl_ex[3:1] !== 3'b001 || u_bus.ex_ctl_ex[0] !== 1'b0) begin errors++; $display("FAIL branch_ctl got %b exp 0010", u_bus.ex_ctl_ex); end
        checks++; if (u_bus.ex_ctl_mem !== 2'b00 || u_bus.ex_ctl_wb !== 2'b00 || u_bus.ex_valid !== 1'b1) begin errors++; $display("FAIL branch_rest got %b %b v%b exp 00 00 v1", u_bus.ex_ctl_mem, u_bus.ex_ctl_wb, u_bus.ex_valid); end
    endtask

    task automatic test_hold();
        set_id(4'b1000, 2'b10, 2'b11, 5'd9, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h500);
        step();
        set_id(4'b0101, 2'b00, 2'b10, 5'd8, 5'd10, 5'd12, 32'h77, 32'h88, 32'h504);
        hold = 1'b1;
        #1;
        checks++; if (u_bus.pc_write !== 1'b0) begin errors++; $display("FAIL hold_pcw got %b exp 0", u_bus.pc_write); end
        step();
        step();
        checks++; if (u_bus.ex_ctl_mem !== 2'b10 || u_bus.ex_rt !== 5'd8 || u_bus.ex_pc4 !== 32'h500 || u_bus.ex_valid !== 1'b1) begin errors++; $display("FAIL hold_regs got %b %0d %h v%b exp 10 8 500 v1", u_bus.ex_ctl_mem, u_bus.ex_rt, u_bus.ex_pc4, u_bus.ex_valid); end
        checks++; if (u_bus.bubble_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL hold_cnt got %0d exp %0d", u_bus.bubble_cnt, exp_cnt); end
        hold = 1'b0;
        step();
        exp_cnt++; exp_small++;
        checks++; if (u_bus.ex_valid !== 1'b0 || u_bus.bubble_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL hold_release got v%b cnt%0d exp v0 cnt%0d", u_bus.ex_valid, u_bus.bubble_cnt, exp_cnt); end
        step();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            set_id(4'b1000, 2'b10, 2'b11, 5'd9, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h600);
            step();
            set_id(4'b0101, 2'b00, 2'b10, 5'd8, 5'd10, 5'd12, 32'h1, 32'h2, 32'h604);
            step();
            step();
            exp_cnt++;
            if (exp_small < 3) exp_small++;
        end
        checks++; if (s_bus.bubble_cnt !== 2'(exp_small) || exp_small != 3) begin errors++; $display("FAIL sat_small got %0d exp 3", s_bus.bubble_cnt); end
        checks++; if (u_bus.bubble_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL sat_wide got %0d exp %0d", u_bus.bubble_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        set_id(4'b1000, 2'b10, 2'b11, 5'd9, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h700);
        step();
        set_id(4'b0101, 2'b00, 2'b10, 5'd8, 5'd10, 5'd12, 32'h1, 32'h2, 32'h704);
        #1;
        checks++; if (u_bus.pc_write !== 1'b0) begin errors++; $display("FAIL mid_pre got %b exp 0", u_bus.pc_write); end
        rst = 1'b0;
        #1;
        checks++; if (u_bus.pc_write !== 1'b1 || u_bus.if_id_write !== 1'b1) begin errors++; $display("FAIL mid_forced got %b%b exp 11", u_bus.pc_write, u_bus.if_id_write); end
        step();
        rst = 1'b1;
        #1;
        checks++; if (u_bus.ex_valid !== 1'b0 || u_bus.ex_ctl_mem !== 2'b00 || u_bus.bubble_cnt !== 16'd0 || s_bus.bubble_cnt !== 2'd0) begin errors++; $display("FAIL mid_clear got v%b mem%b cnt%0d/%0d exp v0 mem00 cnt0/0", u_bus.ex_valid, u_bus.ex_ctl_mem, u_bus.bubble_cnt, s_bus.bubble_cnt); end
        checks++; if (u_bus.pc_write !== 1'b1) begin errors++; $display("FAIL mid_residual got %b exp 1", u_bus.pc_write); end
        step();
        checks++; if (u_bus.ex_valid !== 1'b1 || u_bus.ex_rs !== 5'd8 || u_bus.bubble_cnt !== 16'd0) begin errors++; $display("FAIL mid_resume got v%b rs%0d cnt%0d exp v1 rs8 cnt0", u_bus.ex_valid, u_bus.ex_rs, u_bus.bubble_cnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_cnt = 0;
        exp_small = 0;
        test_reset();
        test_rtype();
        test_load_use();
        test_no_false_hazard();
        test_flush_vs_lu();
        test_hold();
        test_saturation();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
